flt16_to_fix88: RTL and testbench

Sequential half-precision (float16) to signed fixed-point 8.8 converter; the inverse stage that consumes the float16 word the fixed(8.8)→float16 conversion leaves in data memory. On a start request it reads the float16 operand from two bytes of the shared byte-wide data memory. It converts the operand with a one-bit-per-cycle shifter and round-to-nearest-even, then writes the 16-bit two's-complement result back to two memory bytes and raises ack.

---
 rtl/flt16_to_fix88_if.sv | 35 +++
 rtl/flt16_to_fix88.sv | 172 +++++++++++++++++
 tb/tb_flt16_to_fix88.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flt16_to_fix88_if.sv
// Handshake and byte-wide data-memory bus of the float16 -> fixed 8.8 converter.
// The master side is the memory/host; the slave side is the converter itself.
interface flt16_to_fix88_if;
    logic       start;
    logic       ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    // Current converter FSM state, exposed for checkers.
    logic [3:0] dbg_state;

    // start: one-cycle sampled request, honoured only while the converter is idle or done.
    // ack: level, high in DONE until the next accepted start or reset.
    // The memory reads combinationally and writes on the posedge that ends a cycle with mem_wr_en high.
    modport master (
        output start,
        output mem_rd_data,
        input  ack,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        input  dbg_state
    );

    modport slave (
        input  start,
        input  mem_rd_data,
        output ack,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        output dbg_state
    );
endinterface

// File: rtl/flt16_to_fix88.sv
// Sequential float16 -> signed fixed 8.8 converter: reads the operand from memory, shifts one
// bit per cycle with round-to-nearest-even, saturates out-of-range values, writes the result back.
module flt16_to_fix88 #(
    parameter logic [7:0] SRC_ADDR = 8'd2,
    parameter logic [7:0] DST_ADDR = 8'd4
) (
    input  logic             clk,
    input  logic             reset,
    flt16_to_fix88_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_HI  = 4'd1,
        RD_LO  = 4'd2,
        DECODE = 4'd3,
        SHIFT  = 4'd4,
        ROUND  = 4'd5,
        WR_HI  = 4'd6,
        WR_LO  = 4'd7,
        DONE   = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] mag_q, mag_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic        special_q, special_d;
    logic [15:0] res_q, res_d;

    logic        op_sign;
    logic [4:0]  op_exp;
    logic [9:0]  op_man;
    logic [4:0]  dist_up;
    logic [4:0]  dist_dn;
    logic        round_inc;
    logic [15:0] rounded;

    assign op_sign = hi_q[7];
    assign op_exp  = hi_q[6:2];
    assign op_man  = {hi_q[1:0], lo_q};
    // Shift distance d = e - 17, split into a left amount and a right amount.
    assign dist_up = op_exp - 5'd17;
    assign dist_dn = 5'd17 - op_exp;

    // Only the right path has discarded bits, so only it can round up.
    assign round_inc = ~left_q & guard_q & (sticky_q | mag_q[0]);
    assign rounded   = mag_q + {15'd0, round_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hi_q      <= 8'd0;
            lo_q      <= 8'd0;
            mag_q     <= 16'd0;
            cnt_q     <= 4'd0;
            left_q    <= 1'b0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            special_q <= 1'b0;
            res_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            special_q <= special_d;
            res_q     <= res_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        hi_d            = hi_q;
        lo_d            = lo_q;
        mag_d           = mag_q;
        cnt_d           = cnt_q;
        left_d          = left_q;
        guard_d         = guard_q;
        sticky_d        = sticky_q;
        special_d       = special_q;
        res_d           = res_q;
        bus.ack         = 1'b0;
        bus.mem_addr    = 8'd0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 8'd0;

        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RD_HI;
            end
            RD_HI: begin
                bus.mem_addr = SRC_ADDR + 8'd1;
                hi_d         = bus.mem_rd_data;
                state_d      = RD_LO;
            end
            RD_LO: begin
                bus.mem_addr = SRC_ADDR;
                lo_d         = bus.mem_rd_data;
                state_d      = DECODE;
            end
            DECODE: begin
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                left_d   = 1'b0;
                state_d  = ROUND;
                if (op_exp == 5'd0) begin
                    special_d = 1'b1;
                    res_d     = 16'h0000;
                end else if (op_exp >= 5'd22) begin
                    special_d = 1'b1;
                    res_d     = op_sign ? 16'h8000 : 16'h7FFF;
                end else begin
                    special_d = 1'b0;
                    mag_d     = {5'd0, 1'b1, op_man};
                    if (op_exp > 5'd17) begin
                        left_d  = 1'b1;
                        cnt_d   = dist_up[3:0];
                        state_d = SHIFT;
                    end else if (op_exp < 5'd17) begin
                        // Anything shifted right 13 or more places rounds to zero, so cap it.
                        cnt_d   = (dist_dn > 5'd13) ? 4'd13 : dist_dn[3:0];
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = {mag_q[14:0], 1'b0};
                end else begin
                    mag_d    = {1'b0, mag_q[15:1]};
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ROUND;
            end
            ROUND: begin
                if (!special_q) res_d = op_sign ? (~rounded + 16'd1) : rounded;
                state_d = WR_HI;
            end
            WR_HI: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = DST_ADDR + 8'd1;
                bus.mem_wr_data = res_q[15:8];
                state_d         = WR_LO;
            end
            WR_LO: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = DST_ADDR;
                bus.mem_wr_data = res_q[7:0];
                state_d         = DONE;
            end
            DONE: begin
                bus.ack = 1'b1;
                if (bus.start) state_d = RD_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_flt16_to_fix88.sv
// Bench for flt16_to_fix88: directed vectors plus a random sweep against a float model.
module tb_flt16_to_fix88;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;
    logic [15:0] operand = 16'h0000;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flt16_to_fix88_if bus();

    flt16_to_fix88 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory: operand bytes come from the bench, everything else from the array.
    logic [7:0] mem [256];
    assign bus.mem_rd_data = (bus.mem_addr == 8'd2) ? operand[7:0] :
                             (bus.mem_addr == 8'd3) ? operand[15:8] : mem[bus.mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
        end
    end

    // Scoreboard queues
    logic [15:0] exp_q[$];
    int          due_q[$];
    logic [15:0] tag_q[$];
    string       chk_name_q[$];
    logic [31:0] chk_act_q[$];
    logic [31:0] chk_exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic push_chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        chk_name_q.push_back(nm);
        chk_act_q.push_back(act);
        chk_exp_q.push_back(expv);
    endtask

    function automatic int exp_lat(input logic [15:0] f);
        int e;
        e = int'(f[14:10]);
        if (e == 0 || e >= 22) return 6;
        if (e > 17) return 6 + (e - 17);
        if (e < 17) return 6 + (((17 - e) > 13) ? 13 : (17 - e));
        return 6;
    endfunction

    // value * 256 with round-to-nearest-even, saturated to the 16-bit signed range.
    function automatic logic [15:0] model(input logic [15:0] f);
        longint man, q, rem, half, mag;
        int e, k;
        e = int'(f[14:10]);
        if (e == 0) return 16'h0000;
        if (e == 31) return f[15] ? 16'h8000 : 16'h7FFF;
        man = 1024 + longint'(f[9:0]);
        if (e >= 17) begin
            mag = man << (e - 17);
        end else begin
            k    = 17 - e;
            q    = man >> k;
            rem  = man - (q << k);
            half = longint'(1) << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            mag = q;
        end
        if (!f[15]) return (mag > 32767) ? 16'h7FFF : mag[15:0];
        if (mag > 32768) return 16'h8000;
        mag = -mag;
        return mag[15:0];
    endfunction

    // Monitor: drains direct checks and compares each completed conversion.
    logic        ack_prev = 1'b0;
    int          wr_cnt = 0;
    logic [15:0] m_exp, m_tag;
    int          m_due;

    always @(negedge clk) begin
        while (chk_name_q.size() > 0) begin
            string nm;
            logic [31:0] a, x;
            nm = chk_name_q.pop_front();
            a  = chk_act_q.pop_front();
            x  = chk_exp_q.pop_front();
            n_cmp++;
            if (a !== x) begin
                n_err++;
                $display("FAIL %s: got %0h expected %0h", nm, a, x);
            end
        end
        if (bus.mem_wr_en) wr_cnt++;
        if (bus.ack && !ack_prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected no ack", cyc);
            end else begin
                m_exp = exp_q.pop_front();
                m_due = due_q.pop_front();
                m_tag = tag_q.pop_front();
                if ({mem[5], mem[4]} !== m_exp) begin
                    n_err++;
                    $display("FAIL result op=%h: got %h expected %h", m_tag, {mem[5], mem[4]}, m_exp);
                end
                n_cmp++;
                if (cyc != m_due) begin
                    n_err++;
                    $display("FAIL latency op=%h: got ack at cycle %0d expected %0d", m_tag, cyc, m_due);
                end
                n_cmp++;
                if (wr_cnt != 2) begin
                    n_err++;
                    $display("FAIL write_count op=%h: got %0d expected 2", m_tag, wr_cnt);
                end
            end
            wr_cnt = 0;
        end else if (exp_q.size() > 0 && cyc > due_q[0] + 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout op=%h: got no ack by cycle %0d expected by %0d", tag_q[0], cyc, due_q[0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            void'(tag_q.pop_front());
        end
        ack_prev = bus.ack;
    end

    task automatic convert(input logic [15:0] f, input logic [15:0] res, input int hold);
        int t0;
        operand   = f;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        exp_q.push_back(res);
        due_q.push_back(t0 + exp_lat(f));
        tag_q.push_back(f);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
    endtask

    logic [15:0] dir_op  [15] = '{16'h3C00, 16'hBC00, 16'h1C00, 16'h1800, 16'h1A00,
                                  16'h3BFF, 16'h0C00, 16'h57FF, 16'h5800, 16'hD800,
                                  16'h7C00, 16'hFC00, 16'h0000, 16'h8000, 16'h0001};
    logic [15:0] dir_res [15] = '{16'h0100, 16'hFF00, 16'h0001, 16'h0000, 16'h0001,
                                  16'h0100, 16'h0000, 16'h7FF0, 16'h7FFF, 16'h8000,
                                  16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000};

    initial begin
        bus.start = 1'b0;
        #2;
        push_chk("reset_ack", 32'(bus.ack), 32'd0);
        push_chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        push_chk("reset_wr_en", 32'(bus.mem_wr_en), 32'd0);
        push_chk("reset_wr_data", 32'(bus.mem_wr_data), 32'd0);
        push_chk("reset_state", 32'(bus.dbg_state), 32'd0);
        @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) convert(dir_op[i], dir_res[i], 1);

        // start held two cycles, then a new start straight from DONE
        convert(16'h3C00, 16'h0100, 2);
        convert(16'h4000, 16'h0200, 1);

        // reset while shifting 1.0: nothing lands, ack stays low
        begin
            logic [15:0] old;
            old       = {mem[5], mem[4]};
            operand   = 16'h3C00;
            bus.start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            reset = 1'b1;
            #1;
            push_chk("abort_ack", 32'(bus.ack), 32'd0);
            push_chk("abort_wr_en", 32'(bus.mem_wr_en), 32'd0);
            push_chk("abort_state", 32'(bus.dbg_state), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            repeat (12) @(negedge clk);
            push_chk("abort_ack_later", 32'(bus.ack), 32'd0);
            push_chk("abort_mem", 32'({mem[5], mem[4]}), 32'(old));
        end
        convert(16'h3C00, 16'h0100, 1);

        for (int i = 0; i < 100; i++) begin
            logic [15:0] f;
            f[15]    = 1'($urandom_range(0, 1));
            f[14:10] = 5'($urandom_range(0, 30));
            f[9:0]   = 10'($urandom_range(0, 1023));
            convert(f, model(f), 1);
        end

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (i != 4 && i != 5 && mem[i] !== (8'(i) ^ 8'hA5)) bad++;
            push_chk("other_mem_untouched", 32'(bad), 32'd0);
        end
        push_chk("queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t expected earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
